// File: rtl/fpga_clk_ctrl_pkg.sv
// fpga_clk_ctrl shared definitions.
// Mode encodings and the controller state enum.
package fpga_clk_ctrl_pkg;

   localparam logic [1:0] MODE_HALT  = 2'b00;
   localparam logic [1:0] MODE_RUN   = 2'b01;
   localparam logic [1:0] MODE_STEP  = 2'b10;
   localparam logic [1:0] MODE_BURST = 2'b11;

   // State values track the mode encoding one-to-one.
   typedef enum logic [1:0] {
      ST_HALT  = MODE_HALT,
      ST_RUN   = MODE_RUN,
      ST_STEP  = MODE_STEP,
      ST_BURST = MODE_BURST
   } state_t;

   function automatic state_t mode_to_state(
      input logic [1:0] i_m
   );
      return state_t'(i_m);
   endfunction

endpackage

// File: rtl/fpga_clk_ctrl_if.sv
// fpga_clk_ctrl board-side bundle.
// master drives controls, slave is the controller.
interface fpga_clk_ctrl_if #(
   parameter int DIV_WIDTH   = 32,
   parameter int BURST_WIDTH = 16,
   parameter int NUM_PROBES  = 8,
   parameter int PROBE_WIDTH = 32
);

   localparam int SEL_W =
      (NUM_PROBES > 1) ? $clog2(NUM_PROBES) : 1;

   logic [1:0]                        i_mode;
   logic                              i_step_btn;
   logic [BURST_WIDTH-1:0]            i_burst_len;
   logic                              i_div_load;
   logic [DIV_WIDTH-1:0]              i_div_value;
   logic [NUM_PROBES*PROBE_WIDTH-1:0] i_probe_bus;
   logic [SEL_W-1:0]                  i_probe_sel;

   logic                              o_clk;
   logic                              o_clk_en;
   logic                              o_running;
   logic [31:0]                       o_edge_count;
   logic [PROBE_WIDTH-1:0]            o_probe_out;
   logic                              o_probe_nz;

   modport master (
      output i_mode, i_step_btn, i_burst_len,
      output i_div_load, i_div_value,
      output i_probe_bus, i_probe_sel,
      input  o_clk, o_clk_en, o_running,
      input  o_edge_count, o_probe_out, o_probe_nz
   );

   modport slave (
      input  i_mode, i_step_btn, i_burst_len,
      input  i_div_load, i_div_value,
      input  i_probe_bus, i_probe_sel,
      output o_clk, o_clk_en, o_running,
      output o_edge_count, o_probe_out, o_probe_nz
   );

endinterface

// File: rtl/fpga_debounce.sv
// Push-button synchroniser and debouncer.
// Emits a one-cycle pulse on an accepted press.
module fpga_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn,
   output logic o_press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST =
      CW'(DEBOUNCE_CYCLES - 1);

   logic          r_s1;
   logic          r_s2;
   logic          r_level;
   logic          r_press;
   logic [CW-1:0] r_cnt;

   // Two-flop sync, then accept a level held stable long enough.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_level <= 1'b0;
         r_press <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_s1    <= i_btn;
         r_s2    <= r_s1;
         r_press <= 1'b0;
         if (r_s2 != r_level) begin
            if (r_cnt == LAST) begin
               r_level <= r_s2;
               r_press <= r_s2;
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/fpga_clk_ctrl.sv
// CPU clock divider/gater and debug probe capture.
// Rising edges are gated by mode; falling edges never are.
module fpga_clk_ctrl
   import fpga_clk_ctrl_pkg::*;
#(
   parameter int DIV_WIDTH       = 32,
   parameter int DIV_DEFAULT     = 100000000,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int BURST_WIDTH     = 16,
   parameter int NUM_PROBES      = 8,
   parameter int PROBE_WIDTH     = 32
) (
   input  logic            i_clk_gen,
   input  logic            i_rst,
   fpga_clk_ctrl_if.slave  bus
);

   localparam int SEL_W =
      (NUM_PROBES > 1) ? $clog2(NUM_PROBES) : 1;

   logic [DIV_WIDTH-1:0]   r_cnt;
   logic [DIV_WIDTH-1:0]   r_half;
   logic                   r_clk;
   logic                   r_clk_en;
   logic [31:0]            r_edge_cnt;
   logic [BURST_WIDTH-1:0] r_cred;
   state_t                 r_state;
   logic [PROBE_WIDTH-1:0] r_probe;
   logic                   r_probe_nz;

   logic                   w_press;
   logic                   w_mode_chg;
   logic                   w_run;
   logic                   w_gated;
   logic                   w_p_step;
   logic                   w_p_burst;
   logic [BURST_WIDTH-1:0] w_avail;
   logic                   w_perm;
   logic                   w_at_top;
   logic                   w_rise;
   logic                   w_fall;
   logic [DIV_WIDTH-1:0]   w_half_ld;
   logic [PROBE_WIDTH-1:0] w_word;

   fpga_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .i_clk   (i_clk_gen),
      .i_rst   (i_rst),
      .i_btn   (bus.i_step_btn),
      .o_press (w_press)
   );

   assign w_mode_chg =
      (mode_to_state(bus.i_mode) != r_state);
   assign w_run   = (bus.i_mode == MODE_RUN);
   assign w_gated = (bus.i_mode == MODE_STEP) ||
                    (bus.i_mode == MODE_BURST);

   // A press in the same cycle as a mode change is dropped.
   assign w_p_step  = w_press && !w_mode_chg &&
                      (bus.i_mode == MODE_STEP);
   assign w_p_burst = w_press && !w_mode_chg &&
                      (bus.i_mode == MODE_BURST) &&
                      (r_cred == '0);

   // Credits usable this cycle, including a fresh press.
   always_comb begin
      w_avail = r_cred;
      unique case (1'b1)
         w_mode_chg: w_avail = '0;
         w_p_step:   w_avail = BURST_WIDTH'(1);
         w_p_burst:  w_avail = bus.i_burst_len;
         default:    w_avail = r_cred;
      endcase
   end

   assign w_perm = !i_rst &&
      (w_run || (w_gated && (w_avail != '0)));

   assign w_at_top = (r_cnt == r_half - DIV_WIDTH'(1));
   assign w_rise   = !bus.i_div_load && w_at_top &&
                     !r_clk && w_perm;
   assign w_fall   = !bus.i_div_load && w_at_top && r_clk;

   assign w_half_ld = (bus.i_div_value == '0) ?
      DIV_WIDTH'(1) : bus.i_div_value;

   // Select the probe word; out-of-range selects read zero.
   always_comb begin
      w_word = '0;
      for (int k = 0; k < NUM_PROBES; k++) begin
         if (bus.i_probe_sel == SEL_W'(k)) begin
            w_word = bus.i_probe_bus[k*PROBE_WIDTH +:
                                     PROBE_WIDTH];
         end
      end
   end

   // Mode tracking and rising-edge credits.
   always_ff @(posedge i_clk_gen) begin
      if (i_rst) begin
         r_state <= ST_HALT;
         r_cred  <= '0;
      end else begin
         r_state <= mode_to_state(bus.i_mode);
         if (w_rise && !w_run) begin
            r_cred <= w_avail - BURST_WIDTH'(1);
         end else begin
            r_cred <= w_avail;
         end
      end
   end

   // Half-period divider with gated rise, plus edge counter.
   always_ff @(posedge i_clk_gen) begin
      if (i_rst) begin
         r_cnt      <= '0;
         r_half     <= DIV_WIDTH'(DIV_DEFAULT);
         r_clk      <= 1'b0;
         r_clk_en   <= 1'b0;
         r_edge_cnt <= '0;
      end else begin
         r_clk_en <= w_rise;
         if (bus.i_div_load) begin
            r_half <= w_half_ld;
            r_cnt  <= '0;
         end else if (w_fall) begin
            r_clk <= 1'b0;
            r_cnt <= '0;
         end else if (w_rise) begin
            r_clk      <= 1'b1;
            r_cnt      <= '0;
            r_edge_cnt <= r_edge_cnt + 32'd1;
         end else if (!w_at_top) begin
            r_cnt <= r_cnt + DIV_WIDTH'(1);
         end
      end
   end

   // Capture the debug word mid-CPU-cycle on each fall.
   always_ff @(posedge i_clk_gen) begin
      if (i_rst) begin
         r_probe    <= '0;
         r_probe_nz <= 1'b0;
      end else if (w_fall) begin
         r_probe    <= w_word;
         r_probe_nz <= |w_word;
      end
   end

   assign bus.o_clk        = r_clk;
   assign bus.o_clk_en     = r_clk_en;
   assign bus.o_running    = w_perm;
   assign bus.o_edge_count = r_edge_cnt;
   assign bus.o_probe_out  = r_probe;
   assign bus.o_probe_nz   = r_probe_nz;

endmodule
